// File: rtl/lc3_mem_pkg.sv
// Shared constants for the LC-3 memory and memory-mapped I/O subsystem:
// device register addresses, I/O region prefix and status bit positions.
package lc3_mem_pkg;

  localparam logic [6:0]  IO_PREFIX = 7'h7F;
  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

  localparam int KBSR_FULL_BIT = 15;
  localparam int DSR_READY_BIT = 15;
  localparam int DSR_OVF_BIT   = 0;

  function automatic logic is_io_addr(input logic [15:0] addr);
    return addr[15:9] == IO_PREFIX;
  endfunction

endpackage

// File: rtl/lc3_tx_fifo.sv
// Byte FIFO for the display path. A push into a full FIFO is accepted only when
// a pop happens on the same edge; pointers wrap naturally at the power-of-two depth.
module lc3_tx_fifo #(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [7:0]    head,
  output logic [CW-1:0] count
);

  logic [7:0]    mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          pop_s;
  logic          push_s;

  assign full   = (count_r == CW'(DEPTH));
  assign empty  = (count_r == {CW{1'b0}});
  assign head   = mem_r[rd_ptr_r];
  assign count  = count_r;
  assign pop_s  = pop && !empty;
  assign push_s = push && (!full || pop_s);

  // Storage, pointers and occupancy; storage cleared so head reads 8'h00 out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= 8'h00;
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/lc3_mem_io.sv
// LC-3 RAM plus keyboard/display device registers with byte handshakes.
// Define LC3_MEM_IO_TX_FIFO_EN for a TX_DEPTH display FIFO; otherwise a single holding register.
module lc3_mem_io
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int TX_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mar,
  input  logic [15:0] mdr,
  input  logic        memwe,
  output logic [15:0] memOut,
  input  logic [7:0]  kb_data,
  input  logic        kb_valid,
  output logic        kb_ready,
  output logic [7:0]  disp_data,
  output logic        disp_valid,
  input  logic        disp_ready
);

  localparam int CNT_W = $clog2(TX_DEPTH) + 1;

  logic [15:0]          ram_r [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] ram_idx_s;
  logic                 io_s;
  logic [15:0]          rd_data_s;
  logic [15:0]          prev_mar_r;
  logic                 kb_full_r;
  logic [7:0]           kb_byte_r;
  logic                 kb_cap_s;
  logic                 kb_ack_s;
  logic                 tx_ovf_r;
  logic                 ddr_wr_s;
  logic                 dsr_wr_s;
  logic                 tx_pop_s;
  logic                 tx_push_ok_s;
  logic                 tx_full_s;
  logic                 tx_empty_s;
  logic [7:0]           tx_head_s;
  logic [CNT_W-1:0]     tx_count_s;

  assign io_s         = is_io_addr(mar);
  assign ram_idx_s    = mar[ADDR_BITS-1:0];
  assign kb_cap_s     = kb_valid && !kb_full_r;
  assign kb_ack_s     = (mar == KBDR_ADDR) && (prev_mar_r != KBDR_ADDR);
  assign ddr_wr_s     = memwe && (mar == DDR_ADDR);
  assign dsr_wr_s     = memwe && (mar == DSR_ADDR);
  assign tx_pop_s     = disp_ready && !tx_empty_s;
  assign tx_push_ok_s = !tx_full_s || tx_pop_s;

  assign memOut     = rd_data_s;
  assign kb_ready   = !kb_full_r;
  assign disp_valid = (tx_count_s != {CNT_W{1'b0}});
  assign disp_data  = tx_head_s;

`ifdef LC3_MEM_IO_TX_FIFO_EN
  lc3_tx_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (ddr_wr_s),
    .push_data (mdr[7:0]),
    .pop       (disp_ready),
    .full      (tx_full_s),
    .empty     (tx_empty_s),
    .head      (tx_head_s),
    .count     (tx_count_s)
  );
`else
  logic       hold_full_r;
  logic [7:0] hold_data_r;

  assign tx_full_s  = hold_full_r;
  assign tx_empty_s = !hold_full_r;
  assign tx_head_s  = hold_data_r;
  assign tx_count_s = {{(CNT_W-1){1'b0}}, hold_full_r};

  // Single-entry display holding register; refill on the same edge as a drain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_full_r <= 1'b0;
      hold_data_r <= 8'h00;
    end else if (ddr_wr_s && tx_push_ok_s) begin
      hold_full_r <= 1'b1;
      hold_data_r <= mdr[7:0];
    end else if (tx_pop_s) begin
      hold_full_r <= 1'b0;
    end else begin
      hold_full_r <= hold_full_r;
    end
  end
`endif

  // Word RAM; contents survive reset, I/O-region writes never reach it.
  always_ff @(posedge clk) begin
    if (memwe && !io_s) begin
      ram_r[ram_idx_s] <= mdr;
    end
  end

  // Keyboard capture/acknowledge, previous-mar edge detect and sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_mar_r <= 16'h0000;
      kb_full_r  <= 1'b0;
      kb_byte_r  <= 8'h00;
      tx_ovf_r   <= 1'b0;
    end else begin
      prev_mar_r <= mar;
      if (kb_cap_s) begin
        kb_byte_r <= kb_data;
        kb_full_r <= 1'b1;
      end else if (kb_ack_s) begin
        kb_full_r <= 1'b0;
      end else begin
        kb_full_r <= kb_full_r;
      end
      if (ddr_wr_s && !tx_push_ok_s) begin
        tx_ovf_r <= 1'b1;
      end else if (dsr_wr_s && mdr[DSR_OVF_BIT]) begin
        tx_ovf_r <= 1'b0;
      end else begin
        tx_ovf_r <= tx_ovf_r;
      end
    end
  end

  // Read mux: device registers in the I/O page, RAM elsewhere.
  always_comb begin
    rd_data_s = 16'h0000;
    if (io_s) begin
      case (mar)
        KBSR_ADDR: rd_data_s[KBSR_FULL_BIT] = kb_full_r;
        KBDR_ADDR: rd_data_s = {8'h00, kb_byte_r};
        DSR_ADDR: begin
          rd_data_s[DSR_READY_BIT] = !tx_full_s;
          rd_data_s[DSR_OVF_BIT]   = tx_ovf_r;
        end
        default:   rd_data_s = 16'h0000;
      endcase
    end else begin
      rd_data_s = ram_r[ram_idx_s];
    end
  end

endmodule

// File: tb/tb_lc3_mem_io.sv
// Scoreboard bench for lc3_mem_io: stimulus queues expected reads and display bytes,
// a negedge monitor compares them. Follows LC3_MEM_IO_TX_FIFO_EN for the display depth.
module tb_lc3_mem_io;

  localparam int TX_DEPTH = 4;
`ifdef LC3_MEM_IO_TX_FIFO_EN
  localparam int EFF = TX_DEPTH;
`else
  localparam int EFF = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mar;
  logic [15:0] mdr;
  logic        memwe;
  logic [15:0] memOut;
  logic [7:0]  kb_data;
  logic        kb_valid;
  logic        kb_ready;
  logic [7:0]  disp_data;
  logic        disp_valid;
  logic        disp_ready;

  lc3_mem_io #(.ADDR_BITS(8), .TX_DEPTH(TX_DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .mar        (mar),
    .mdr        (mdr),
    .memwe      (memwe),
    .memOut     (memOut),
    .kb_data    (kb_data),
    .kb_valid   (kb_valid),
    .kb_ready   (kb_ready),
    .disp_data  (disp_data),
    .disp_valid (disp_valid),
    .disp_ready (disp_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sel;   // 0 memOut, 1 kb_ready, 2 disp_valid, 3 disp_data
    logic [15:0] exp;
  } chk_t;

  chk_t       chk_q[$];
  logic [7:0] disp_model[$];
  logic       ovf_m;
  int         n_checks = 0;
  int         n_fail   = 0;

  // Monitor: drain this cycle's expectations and score every display handshake.
  always @(negedge clk) begin
    chk_t        c;
    logic [15:0] act;
    logic [7:0]  eb;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      case (c.sel)
        0:       act = memOut;
        1:       act = {15'd0, kb_ready};
        2:       act = {15'd0, disp_valid};
        default: act = {8'h00, disp_data};
      endcase
      n_checks++;
      if (act !== c.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
      end
    end
    if (reset && disp_valid && disp_ready) begin
      n_checks++;
      if (disp_model.size() == 0) begin
        n_fail++;
        $display("FAIL disp_pop: got byte %h expected no byte", disp_data);
      end else begin
        eb = disp_model.pop_front();
        if (disp_data !== eb) begin
          n_fail++;
          $display("FAIL disp_pop: got %h expected %h", disp_data, eb);
        end
      end
    end
  end

  task automatic expect_sig(input string name, input int sel, input logic [15:0] exp);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    memwe    = 1'b0;
    kb_valid = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    mar   = a;
    mdr   = d;
    memwe = 1'b1;
  endtask

  // Display write; model decides acceptance from current occupancy and disp_ready.
  task automatic ddr_write(input logic [7:0] b);
    wr(16'hFE06, {8'h00, b});
    if (disp_model.size() < EFF || (disp_ready && disp_model.size() > 0))
      disp_model.push_back(b);
    else
      ovf_m = 1'b1;
  endtask

  function automatic logic [15:0] dsr_exp();
    logic rdy;
    rdy = (disp_model.size() < EFF);
    return {rdy, 14'd0, ovf_m};
  endfunction

  initial begin
    reset = 1'b0; mar = 16'hFE00; mdr = 16'h0000; memwe = 1'b0;
    kb_data = 8'h00; kb_valid = 1'b0; disp_ready = 1'b0; ovf_m = 1'b0;
    expect_sig("rst_kbsr", 0, 16'h0000);
    expect_sig("rst_kb_ready", 1, 16'h0001);
    expect_sig("rst_disp_valid", 2, 16'h0000);
    expect_sig("rst_disp_data", 3, 16'h0000);
    step();
    reset = 1'b1;
    step();

    // RAM write/read, alias and read-during-write
    wr(16'h0010, 16'h1234); step();
    idle(); expect_sig("ram_rd", 0, 16'h1234); step();
    mar = 16'h0110; expect_sig("ram_alias", 0, 16'h1234); step();
    wr(16'h0020, 16'h1111); step();
    wr(16'h0020, 16'h2222); expect_sig("rdw_old", 0, 16'h1111); step();
    idle(); expect_sig("rdw_new", 0, 16'h2222); step();

    // Keyboard capture and acknowledge
    mar = 16'hFE00; kb_valid = 1'b1; kb_data = 8'h41;
    expect_sig("kb_pre_kbsr", 0, 16'h0000); expect_sig("kb_pre_ready", 1, 16'h0001); step();
    idle(); expect_sig("kb_kbsr_full", 0, 16'h8000); expect_sig("kb_ready_lo", 1, 16'h0000); step();
    mar = 16'hFE02;
    expect_sig("kbdr_c1", 0, 16'h0041); expect_sig("kb_ack_c1", 1, 16'h0000); step();
    expect_sig("kbdr_c2", 0, 16'h0041); expect_sig("kb_ack_c2", 1, 16'h0001); step();
    expect_sig("kbdr_c3", 0, 16'h0041); expect_sig("kb_ack_c3", 1, 16'h0001); step();
    mar = 16'hFE00; expect_sig("kbsr_clr", 0, 16'h0000); step();

    // Ack edge with kb_valid high captures only on the following edge
    kb_valid = 1'b1; kb_data = 8'h42; step();
    mar = 16'hFE02; kb_data = 8'h43;
    expect_sig("kbdr_42", 0, 16'h0042); expect_sig("kb_full_42", 1, 16'h0000); step();
    expect_sig("kbdr_hold", 0, 16'h0042); expect_sig("kb_ready_gap", 1, 16'h0001); step();
    kb_valid = 1'b0;
    expect_sig("kbdr_43", 0, 16'h0043); expect_sig("kb_full_43", 1, 16'h0000); step();
    mar = 16'hFE00; expect_sig("kbsr_43", 0, 16'h8000); step();

    // Display with stall, then drain
    disp_ready = 1'b0;
    ddr_write(8'h61); expect_sig("disp_v_pre", 2, 16'h0000); step();
    ddr_write(8'h62); expect_sig("disp_v_61", 2, 16'h0001); expect_sig("disp_d_61", 3, 16'h0061); step();
    idle(); disp_ready = 1'b1; step();
    step();
    expect_sig("disp_v_drained", 2, 16'h0000); step();
    mar = 16'hFE04; expect_sig("dsr_after_stall", 0, dsr_exp()); step();
    wr(16'hFE04, 16'h0001); step();
    idle(); disp_ready = 1'b0; step();

    // Overflow and DSR clear
    for (int i = 0; i < 5; i++) begin
      ddr_write(8'h70 + 8'(i)); step();
    end
    idle(); mar = 16'hFE04; expect_sig("dsr_ovf", 0, dsr_exp()); step();
    wr(16'hFE04, 16'h0001); ovf_m = 1'b0; step();
    idle(); mar = 16'hFE04; expect_sig("dsr_ovf_clr", 0, dsr_exp()); step();

    // Full FIFO with simultaneous push and pop
    disp_ready = 1'b1; ddr_write(8'h77); step();
    idle(); disp_ready = 1'b0; mar = 16'hFE04; expect_sig("dsr_full_pushpop", 0, dsr_exp()); step();
    disp_ready = 1'b1;
    repeat (EFF + 2) step();
    expect_sig("disp_v_final", 2, 16'h0000); step();

    // Reset mid-operation: FIFO and flags cleared, RAM kept
    disp_ready = 1'b0;
    wr(16'h0030, 16'hBEEF); step();
    ddr_write(8'h81); step();
    ddr_write(8'h82); step();
    idle(); mar = 16'hFE00; expect_sig("pre_rst_kbsr", 0, 16'h8000); expect_sig("pre_rst_dv", 2, 16'h0001); step();
    reset = 1'b0; disp_model.delete(); ovf_m = 1'b0;
    expect_sig("mid_rst_kbsr", 0, 16'h0000); expect_sig("mid_rst_kb_ready", 1, 16'h0001);
    expect_sig("mid_rst_dv", 2, 16'h0000); step();
    reset = 1'b1; mar = 16'h0030; expect_sig("ram_kept", 0, 16'hBEEF); step();
    mar = 16'hFE04; expect_sig("dsr_post_rst", 0, dsr_exp()); step();
    step();

    n_checks++;
    if (disp_model.size() != 0) begin
      n_fail++;
      $display("FAIL disp_leftover: got %0d bytes pending expected 0", disp_model.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
